// File: rtl/vec_mem_seq.sv
// Strided vector mover between a streaming interface and a dual-port RAM:
// port A serves a prefetching read job, port B a write job; the two run concurrently.
module vec_mem_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] rd_stride,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic                  wr_start,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic [ADDR_WIDTH-1:0] wr_stride,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    output logic                  wr_busy,
    output logic                  wr_done,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din_b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                rd_state_r, rd_state_next_s;
    logic [LEN_WIDTH-1:0]  rd_len_r;
    logic [ADDR_WIDTH-1:0] rd_stride_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [LEN_WIDTH-1:0]  rd_issued_r;
    logic [LEN_WIDTH-1:0]  rd_popped_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] fifo_r [4];
    logic [1:0]            wp_r;
    logic [1:0]            rp_r;
    logic [2:0]            count_r;

    state_t                wr_state_r, wr_state_next_s;
    logic [LEN_WIDTH-1:0]  wr_len_r;
    logic [ADDR_WIDTH-1:0] wr_stride_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [LEN_WIDTH-1:0]  wr_cnt_r;

    logic [2:0]            occupancy_s;
    logic                  issue_req_s;
    logic                  collision_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  rd_valid_s;
    logic                  wr_accept_s;

    // Read issue, collision and FIFO handshake decisions
    always_comb begin
        occupancy_s = count_r + {2'b00, inflight_r};
        wr_accept_s = (wr_state_r == S_RUN) && wr_valid && !rst;
        issue_req_s = (rd_state_r == S_RUN) && (rd_issued_r != rd_len_r) &&
                      (occupancy_s < 3'd4) && !rst;
        // Port B writes in the same cycle win; the read retries on the next cycle
        collision_s = wr_accept_s && (rd_addr_r == wr_addr_r);
        issue_s     = issue_req_s && !collision_s;
        // A pending return is only trusted if its issue survived any reset
        push_s      = inflight_r;
        rd_valid_s  = (count_r != 3'd0) && !rst;
        pop_s       = rd_valid_s && rd_ready;
    end

    // Read FSM next state
    always_comb begin
        rd_state_next_s = rd_state_r;
        case (rd_state_r)
            S_IDLE: begin
                if (rd_start) begin
                    if (rd_len == {LEN_WIDTH{1'b0}}) begin
                        rd_state_next_s = S_DONE;
                    end else begin
                        rd_state_next_s = S_RUN;
                    end
                end else begin
                    rd_state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (pop_s && ((rd_popped_r + LEN_WIDTH'(1)) == rd_len_r)) begin
                    rd_state_next_s = S_DONE;
                end else begin
                    rd_state_next_s = S_RUN;
                end
            end
            S_DONE:  rd_state_next_s = S_IDLE;
            default: rd_state_next_s = S_IDLE;
        endcase
    end

    // Read FSM state, descriptor, address accumulator and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r  <= S_IDLE;
            rd_len_r    <= {LEN_WIDTH{1'b0}};
            rd_stride_r <= {ADDR_WIDTH{1'b0}};
            rd_addr_r   <= {ADDR_WIDTH{1'b0}};
            rd_issued_r <= {LEN_WIDTH{1'b0}};
            rd_popped_r <= {LEN_WIDTH{1'b0}};
            inflight_r  <= 1'b0;
            wp_r        <= 2'd0;
            rp_r        <= 2'd0;
            count_r     <= 3'd0;
        end else begin
            rd_state_r <= rd_state_next_s;
            if ((rd_state_r == S_IDLE) && rd_start) begin
                rd_len_r    <= rd_len;
                rd_stride_r <= rd_stride;
                rd_addr_r   <= rd_base;
                rd_issued_r <= {LEN_WIDTH{1'b0}};
                rd_popped_r <= {LEN_WIDTH{1'b0}};
            end else begin
                if (issue_s) begin
                    rd_addr_r   <= rd_addr_r + rd_stride_r;
                    rd_issued_r <= rd_issued_r + LEN_WIDTH'(1);
                end
                if (pop_s) begin
                    rd_popped_r <= rd_popped_r + LEN_WIDTH'(1);
                end
            end
            inflight_r <= issue_s;
            if (push_s) begin
                wp_r <= wp_r + 2'd1;
            end
            if (pop_s) begin
                rp_r <= rp_r + 2'd1;
            end
            count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
        end
    end

    // FIFO storage; contents are meaningless while count_r says empty
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_r[wp_r] <= ram_dout_a;
        end
    end

    // Write FSM next state
    always_comb begin
        wr_state_next_s = wr_state_r;
        case (wr_state_r)
            S_IDLE: begin
                if (wr_start) begin
                    if (wr_len == {LEN_WIDTH{1'b0}}) begin
                        wr_state_next_s = S_DONE;
                    end else begin
                        wr_state_next_s = S_RUN;
                    end
                end else begin
                    wr_state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (wr_accept_s && ((wr_cnt_r + LEN_WIDTH'(1)) == wr_len_r)) begin
                    wr_state_next_s = S_DONE;
                end else begin
                    wr_state_next_s = S_RUN;
                end
            end
            S_DONE:  wr_state_next_s = S_IDLE;
            default: wr_state_next_s = S_IDLE;
        endcase
    end

    // Write FSM state, descriptor and address accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r  <= S_IDLE;
            wr_len_r    <= {LEN_WIDTH{1'b0}};
            wr_stride_r <= {ADDR_WIDTH{1'b0}};
            wr_addr_r   <= {ADDR_WIDTH{1'b0}};
            wr_cnt_r    <= {LEN_WIDTH{1'b0}};
        end else begin
            wr_state_r <= wr_state_next_s;
            if ((wr_state_r == S_IDLE) && wr_start) begin
                wr_len_r    <= wr_len;
                wr_stride_r <= wr_stride;
                wr_addr_r   <= wr_base;
                wr_cnt_r    <= {LEN_WIDTH{1'b0}};
            end else if (wr_accept_s) begin
                wr_addr_r <= wr_addr_r + wr_stride_r;
                wr_cnt_r  <= wr_cnt_r + LEN_WIDTH'(1);
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_cnt_r  <= wr_cnt_r;
            end
        end
    end

    // Output drive; everything is held at zero while rst is high
    always_comb begin
        ram_we_a   = 1'b0;
        ram_din_a  = {DATA_WIDTH{1'b0}};
        ram_addr_a = issue_s ? rd_addr_r : {ADDR_WIDTH{1'b0}};
        ram_we_b   = wr_accept_s;
        ram_addr_b = wr_accept_s ? wr_addr_r : {ADDR_WIDTH{1'b0}};
        ram_din_b  = wr_accept_s ? wr_data : {DATA_WIDTH{1'b0}};
        wr_ready   = (wr_state_r == S_RUN) && !rst;
        rd_valid   = rd_valid_s;
        rd_data    = rd_valid_s ? fifo_r[rp_r] : {DATA_WIDTH{1'b0}};
        rd_busy    = (rd_state_r != S_IDLE) && !rst;
        rd_done    = (rd_state_r == S_DONE) && !rst;
        wr_busy    = (wr_state_r != S_IDLE) && !rst;
        wr_done    = (wr_state_r == S_DONE) && !rst;
    end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Scoreboard bench for vec_mem_seq with a synchronous read-first dual-port RAM model.
module tb_vec_mem_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_start, rd_busy, rd_done, rd_valid, rd_ready;
    logic [9:0] rd_base, rd_stride;
    logic [10:0] rd_len;
    logic [7:0] rd_data;
    logic       wr_start, wr_busy, wr_done, wr_valid, wr_ready;
    logic [9:0] wr_base, wr_stride;
    logic [10:0] wr_len;
    logic [7:0] wr_data;
    logic       ram_we_a, ram_we_b;
    logic [9:0] ram_addr_a, ram_addr_b;
    logic [7:0] ram_din_a, ram_dout_a, ram_din_b;

    logic [7:0] mem [1024];
    logic [7:0] exp_q [$];
    logic [7:0] wdata [8];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vec_mem_seq dut (
        .clk(clk), .rst(rst),
        .rd_start(rd_start), .rd_base(rd_base), .rd_stride(rd_stride), .rd_len(rd_len),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .wr_start(wr_start), .wr_base(wr_base), .wr_stride(wr_stride), .wr_len(wr_len),
        .wr_busy(wr_busy), .wr_done(wr_done), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
        .ram_dout_a(ram_dout_a),
        .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b)
    );

    // Read-first RAM: a same-cycle read of a written address returns the old word
    always @(posedge clk) begin
        if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        ram_dout_a <= mem[ram_addr_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and watches port A/B clashes
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {24'd0, rd_data}, 32'hFFFF_FFFF);
            end else begin
                check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (!rst && ram_we_b && ram_addr_a != 10'd0) begin
            check("port_collision", {31'd0, ram_addr_a == ram_addr_b}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, {25'd0, rd_busy, rd_done, rd_valid, wr_busy, wr_done, wr_ready, ram_we_b}, 32'd0);
        check({name, "_bus"}, {ram_addr_a, ram_addr_b, rd_data, ram_we_a, ram_din_a[3:0]}, 32'd0);
    endtask

    task automatic rd_job(input logic [9:0] base, input logic [9:0] stride,
                          input logic [10:0] len, input int bound);
        bit seen = 1'b0;
        rd_base = base; rd_stride = stride; rd_len = len; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int t = 0; t < bound && !seen; t++) begin
            @(negedge clk);
            if (rd_done) seen = 1'b1;
            tick();
        end
        check("rd_done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wr_job(input logic [9:0] base, input logic [9:0] stride, input int n);
        int j = 0;
        wr_base = base; wr_stride = stride; wr_len = 11'(n); wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        for (int t = 0; t < 40 && j < n; t++) begin
            wr_valid = 1'b1;
            wr_data  = wdata[j];
            @(negedge clk);
            if (wr_ready) j++;
            tick();
        end
        wr_valid = 1'b0;
        wr_data  = 8'd0;
        check("wr_beats", j, n);
        @(negedge clk);
        check("wr_done_after_last", {31'd0, wr_done}, 32'd1);
        tick();
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        rst = 1'b1; rd_start = 1'b0; wr_start = 1'b0; rd_ready = 1'b1;
        wr_valid = 1'b0; wr_data = 8'd0;
        rd_base = 10'd0; rd_stride = 10'd0; rd_len = 11'd0;
        wr_base = 10'd0; wr_stride = 10'd0; wr_len = 11'd0;
        repeat (3) tick();
        @(negedge clk);
        check_idle_outputs("in_reset");
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("after_reset");

        // Plain read with exact cycle timing
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        rd_base = 10'h010; rd_stride = 10'd1; rd_len = 11'd4; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("plain_valid_c%0d", k), {31'd0, rd_valid}, {31'd0, (k >= 3 && k <= 6)});
            check($sformatf("plain_done_c%0d", k), {31'd0, rd_done}, {31'd0, k == 7});
        end
        tick();
        check("plain_drained", exp_q.size(), 0);

        // Backpressure with rd_ready pattern 1,0,0,1
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        rd_base = 10'h010; rd_stride = 10'd1; rd_len = 11'd4; rd_start = 1'b1;
        seen = 1'b0;
        for (int p = 0; p < 60 && !seen; p++) begin
            rd_ready = ((p % 4) == 0) || ((p % 4) == 3);
            if (p == 1) rd_start = 1'b0;
            @(negedge clk);
            if (rd_done) seen = 1'b1;
            tick();
        end
        rd_start = 1'b0;
        rd_ready = 1'b1;
        check("bp_done_seen", {31'd0, seen}, 32'd1);
        check("bp_drained", exp_q.size(), 0);

        // Write with stride wrap-around
        wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
        wr_job(10'h3FE, 10'd3, 3);
        check("wrap_3fe", {24'd0, mem[10'h3FE]}, 32'hA1);
        check("wrap_001", {24'd0, mem[10'h001]}, 32'hB2);
        check("wrap_004", {24'd0, mem[10'h004]}, 32'hC3);

        // Concurrent read and write over the same region
        for (int i = 0; i < 8; i++) begin
            mem[10'h20 + 10'(i)] = 8'h00;
            wdata[i] = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
        end
        fork
            wr_job(10'h020, 10'd1, 8);
            rd_job(10'h020, 10'd1, 11'd8, 40);
        join
        check("coll_drained", exp_q.size(), 0);

        // Zero-length read
        rd_base = 10'h100; rd_stride = 10'd1; rd_len = 11'd0; rd_start = 1'b1;
        @(negedge clk);
        check("len0_c0_addr", {22'd0, ram_addr_a}, 32'd0);
        tick();
        rd_start = 1'b0;
        @(negedge clk);
        check("len0_done_c1", {31'd0, rd_done}, 32'd1);
        check("len0_addr_c1", {22'd0, ram_addr_a}, 32'd0);
        tick();
        @(negedge clk);
        check("len0_idle_c2", {30'd0, rd_done, rd_valid}, 32'd0);
        check("len0_addr_c2", {22'd0, ram_addr_a}, 32'd0);
        tick();

        // Reset in the middle of an 8-beat read, then a clean follow-up job
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
        rd_base = 10'h040; rd_stride = 10'd1; rd_len = 11'd8; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_mid_reset");
        tick();
        repeat (3) begin
            @(negedge clk);
            check("post_reset_quiet", {31'd0, rd_valid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h50 + 8'(i * 2));
        rd_job(10'h050, 10'd2, 11'd3, 40);
        check("after_reset_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
